// File: rtl/multi_channel_watchdog.sv
// multi_channel_watchdog
//
// Supervises NUM_CH independent heartbeat sources. Each channel has its own
// timeout counter and IDLE/ARMED/HOLD state machine. A channel trips when it
// goes TIMEOUT cycles without a heartbeat. It then holds force_reset high for
// RST_HOLD cycles, latches a sticky triggered flag, bumps a saturating trip
// counter and re-arms on its own.
//
// Optional feature macro: WDT_WINDOW_EN
//   When defined, a heartbeat that arrives while the counter is still below
//   WINDOW_MIN counts as an early-kick fault. It trips the channel exactly
//   like a timeout and also sets the sticky early_fault flag.
//
// Ports:
//   clk             system clock
//   rst             synchronous, active-high reset
//   enable          per-channel enable
//   heartbeat       per-channel kick, level-high sampled every cycle
//   clear_trip      per-channel clear of triggered (and early_fault)
//   warning         channel armed and counter >= WARN_LEVEL
//   triggered       sticky per-channel trip flag
//   force_reset     per-channel reset pulse, RST_HOLD cycles wide
//   force_reset_any OR of force_reset
//   trip_count      saturating trip counts, channel i at [i*TRIP_CNT_W +: TRIP_CNT_W]
//   early_fault     (WDT_WINDOW_EN only) sticky early-kick flag
module multi_channel_watchdog #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 32,
  parameter int TIMEOUT    = 50_000_000,
  parameter int WARN_LEVEL = 40_000_000,
  parameter int RST_HOLD   = 16,
  parameter int TRIP_CNT_W = 8,
  parameter int WINDOW_MIN = 1_000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            enable,
  input  logic [NUM_CH-1:0]            heartbeat,
  input  logic [NUM_CH-1:0]            clear_trip,
  output logic [NUM_CH-1:0]            warning,
  output logic [NUM_CH-1:0]            triggered,
  output logic [NUM_CH-1:0]            force_reset,
  output logic                         force_reset_any,
  output logic [NUM_CH*TRIP_CNT_W-1:0] trip_count
`ifdef WDT_WINDOW_EN
  ,
  output logic [NUM_CH-1:0]            early_fault
`endif
);

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  localparam logic [CNT_W-1:0]      TRIP_AT   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]      WARN_AT   = CNT_W'(WARN_LEVEL);
  localparam logic [HOLD_W-1:0]     HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [TRIP_CNT_W-1:0] TRIP_MAX  = '1;
`ifdef WDT_WINDOW_EN
  localparam logic [CNT_W-1:0]      WIN_AT    = CNT_W'(WINDOW_MIN);
`endif

  // Refuse to elaborate with a configuration that cannot behave sensibly.
  if (NUM_CH < 1 || NUM_CH > 16 || TIMEOUT <= WARN_LEVEL || RST_HOLD < 1 ||
      WINDOW_MIN >= TIMEOUT) begin : g_bad_params
    $error("multi_channel_watchdog: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HOLD  = 2'd2
  } ch_state_t;

  ch_state_t             state_q    [NUM_CH];
  ch_state_t             state_d    [NUM_CH];
  logic [CNT_W-1:0]      count_q    [NUM_CH];
  logic [CNT_W-1:0]      count_d    [NUM_CH];
  logic [HOLD_W-1:0]     hold_q     [NUM_CH];
  logic [HOLD_W-1:0]     hold_d     [NUM_CH];
  logic [TRIP_CNT_W-1:0] trip_cnt_q [NUM_CH];
  logic [TRIP_CNT_W-1:0] trip_cnt_d [NUM_CH];

  logic [NUM_CH-1:0] trip_ev;
  logic [NUM_CH-1:0] warning_d;
  logic [NUM_CH-1:0] triggered_d;
  logic [NUM_CH-1:0] force_d;
  logic              force_any_d;
`ifdef WDT_WINDOW_EN
  logic [NUM_CH-1:0] early_ev;
  logic [NUM_CH-1:0] early_d;
`endif

  // State register: every channel's FSM state, counters and all registered
  // outputs update together on the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]    <= IDLE;
        count_q[i]    <= '0;
        hold_q[i]     <= '0;
        trip_cnt_q[i] <= '0;
      end
      warning         <= '0;
      triggered       <= '0;
      force_reset     <= '0;
      force_reset_any <= 1'b0;
`ifdef WDT_WINDOW_EN
      early_fault     <= '0;
`endif
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]    <= state_d[i];
        count_q[i]    <= count_d[i];
        hold_q[i]     <= hold_d[i];
        trip_cnt_q[i] <= trip_cnt_d[i];
      end
      warning         <= warning_d;
      triggered       <= triggered_d;
      force_reset     <= force_d;
      force_reset_any <= force_any_d;
`ifdef WDT_WINDOW_EN
      early_fault     <= early_d;
`endif
    end
  end

  // Next-state logic per channel. In ARMED the priority is: disable, then
  // heartbeat, then timeout, then count up. The trip fires on the cycle the
  // counter sits at TIMEOUT-1. The first force_reset therefore appears TIMEOUT
  // cycles after the arm or the last kick, and the counter never wraps.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      count_d[i] = count_q[i];
      hold_d[i]  = hold_q[i];
      trip_ev[i] = 1'b0;
`ifdef WDT_WINDOW_EN
      early_ev[i] = 1'b0;
`endif
      case (state_q[i])
        IDLE: begin
          count_d[i] = '0;
          if (enable[i]) begin
            state_d[i] = ARMED;
          end
        end
        ARMED: begin
          if (!enable[i]) begin
            state_d[i] = IDLE;
            count_d[i] = '0;
          end else if (heartbeat[i]) begin
`ifdef WDT_WINDOW_EN
            if (count_q[i] < WIN_AT) begin
              early_ev[i] = 1'b1;
              trip_ev[i]  = 1'b1;
            end
`endif
            count_d[i] = '0;
          end else if (count_q[i] == TRIP_AT) begin
            trip_ev[i] = 1'b1;
          end else begin
            count_d[i] = count_q[i] + 1'b1;
          end
          if (trip_ev[i]) begin
            state_d[i] = HOLD;
            count_d[i] = '0;
            hold_d[i]  = '0;
          end
        end
        HOLD: begin
          // Heartbeat and enable are ignored until the pulse completes. Only
          // the exit decision looks at enable.
          count_d[i] = '0;
          if (hold_q[i] == HOLD_LAST) begin
            hold_d[i] = '0;
            if (enable[i]) begin
              state_d[i] = ARMED;
            end else begin
              state_d[i] = IDLE;
            end
          end else begin
            hold_d[i] = hold_q[i] + 1'b1;
          end
        end
        default: begin
          state_d[i] = IDLE;
          count_d[i] = '0;
          hold_d[i]  = '0;
        end
      endcase
    end
  end

  // Output logic. The outputs are computed from next-state values so the
  // registered outputs line up with the state they describe. A new trip beats
  // a coincident clear_trip.
  always_comb begin
    warning_d   = '0;
    triggered_d = '0;
    force_d     = '0;
`ifdef WDT_WINDOW_EN
    early_d     = '0;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      warning_d[i] = (state_d[i] == ARMED) && (count_d[i] >= WARN_AT);
      force_d[i]   = (state_d[i] == HOLD);
      if (trip_ev[i]) begin
        triggered_d[i] = 1'b1;
      end else if (clear_trip[i]) begin
        triggered_d[i] = 1'b0;
      end else begin
        triggered_d[i] = triggered[i];
      end
      trip_cnt_d[i] = trip_cnt_q[i];
      if (trip_ev[i] && (trip_cnt_q[i] != TRIP_MAX)) begin
        trip_cnt_d[i] = trip_cnt_q[i] + 1'b1;
      end
`ifdef WDT_WINDOW_EN
      if (early_ev[i]) begin
        early_d[i] = 1'b1;
      end else if (clear_trip[i]) begin
        early_d[i] = 1'b0;
      end else begin
        early_d[i] = early_fault[i];
      end
`endif
    end
    force_any_d = |force_d;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_trip_out
    assign trip_count[g*TRIP_CNT_W +: TRIP_CNT_W] = trip_cnt_q[g];
  end

endmodule
